// File: rtl/xfer_sched_pkg.sv
// xfer_sched_pkg: shared FSM encoding and sizing constants for fifo_xfer_sched.
package xfer_sched_pkg;
  typedef enum logic [1:0] {IDLE, START, RUN, STOP} state_t;
  localparam int XFER_LEN_W = 8;
  localparam int TIMEOUT_CYC_DEF = 255;
endpackage

// File: rtl/fifo_xfer_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from last_owner+1 upward.
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_owner,
  output logic [N-1:0] winner
);
  // Scan from lowest to highest priority so the nearest requester after last_owner overwrites the rest.
  always_comb begin
    winner = '0;
    for (int i = N; i >= 1; i--) begin
      if (((req >> ((int'(last_owner) + i) % N)) & N'(1)) != '0) winner = N'(1) << ((int'(last_owner) + i) % N);
    end
  end
endmodule

// File: rtl/fifo_xfer_sched.sv
// fifo_xfer_sched: round-robin scheduler handing a byte-transfer engine to one requester at a time.
// Define XFER_SCHED_TIMEOUT_EN to add a RUN-state watchdog that aborts transfers whose strobes stall.
module fifo_xfer_sched
  import xfer_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [XFER_LEN_W*NUM_REQ-1:0]    req_len,
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               done,
  output logic [NUM_REQ-1:0]               abort,
  output logic                             eng_start,
  output logic                             eng_stop,
  output logic [XFER_LEN_W-1:0]            eng_len,
  input  logic                             eng_byte,
  output logic                             busy
);
  localparam int OW = $clog2(NUM_REQ);
  state_t state, state_n;
  logic [OW-1:0] owner, last_owner, win_idx;
  logic [NUM_REQ-1:0] win, owner_oh;
  logic [XFER_LEN_W-1:0] len, cnt, win_len;
  logic cnt_hit, wd_hit, aborting;
  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("fifo_xfer_sched: NUM_REQ must be 2..4 and TIMEOUT_CYC positive");
  end
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req),
    .last_owner(last_owner),
    .winner    (win)
  );
  always_comb begin
    win_idx = '0;
    win_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_idx = win[i] ? OW'(i) : win_idx;
      win_len = win[i] ? req_len[XFER_LEN_W*i +: XFER_LEN_W] : win_len;
    end
  end
  assign cnt_hit = cnt == len;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = |req ? START : IDLE;
      START:   state_n = len == '0 ? IDLE : RUN;
      RUN:     state_n = (cnt_hit || wd_hit) ? STOP : RUN;
      STOP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Zero-length grants finish in START, so last_owner advances there as well as in STOP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= '0;
      owner_oh   <= '0;
      last_owner <= OW'(NUM_REQ - 1);
      len        <= '0;
      cnt        <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |req) begin
        owner    <= win_idx;
        owner_oh <= win;
        len      <= win_len;
        cnt      <= '0;
      end
      if (state == RUN && eng_byte && !cnt_hit) cnt <= cnt + 1'b1;
      if (state == STOP || (state == START && len == '0)) last_owner <= owner;
    end
  end
`ifdef XFER_SCHED_TIMEOUT_EN
  logic [$clog2(TIMEOUT_CYC+1)-1:0] wd;
  // Expires on the TIMEOUT_CYC-th consecutive strobe-less RUN cycle; a completed count wins.
  assign wd_hit = state == RUN && !eng_byte && !cnt_hit && int'(wd) + 1 >= TIMEOUT_CYC;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wd       <= '0;
      aborting <= 1'b0;
    end else begin
      wd       <= (state == RUN && !eng_byte) ? wd + 1'b1 : '0;
      aborting <= state == RUN ? wd_hit : state == STOP && aborting;
    end
  end
  assign abort = state == STOP && aborting ? owner_oh : '0;
`else
  assign wd_hit   = 1'b0;
  assign aborting = 1'b0;
  assign abort    = '0;
`endif
  assign busy      = state != IDLE;
  assign grant     = busy ? owner_oh : '0;
  assign done      = (state == STOP && !aborting) || (state == START && len == '0) ? owner_oh : '0;
  assign eng_start = state == START && len != '0;
  assign eng_stop  = state == STOP;
  assign eng_len   = busy ? len : '0;
endmodule

// File: tb/tb_fifo_xfer_sched.sv
// tb_fifo_xfer_sched: randomized and directed stimulus; a transaction-level model queues expected
// grants, which a negedge monitor checks against every grant/done/abort the DUT presents.
module tb_fifo_xfer_sched;
  localparam int N = 2;
  localparam int TO = 10;
  logic clk = 1'b0, reset_n = 1'b0, eng_byte = 1'b0;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] req_len = '0;
  logic [N-1:0] grant, done, abort;
  logic eng_start, eng_stop, busy;
  logic [7:0] eng_len;
  int checks = 0, failures = 0, cyc = 0, done_cnt = 0, mode = 0, exp_ev_cyc = -1, m_last = N - 1;
  bit exact_occ = 1'b0;
  typedef struct { int idx; int len; bit ab; } exp_t;
  exp_t exp_q[$];

  fifo_xfer_sched #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_len(req_len), .grant(grant), .done(done),
    .abort(abort), .eng_start(eng_start), .eng_stop(eng_stop), .eng_len(eng_len),
    .eng_byte(eng_byte), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_next(input int last, input logic [N-1:0] m);
    for (int j = 1; j <= N; j++) if (((int'(m) >> ((last + j) % N)) & 1) != 0) return (last + j) % N;
    return 0;
  endfunction

  // Monitor: every busy cycle must belong to the transfer at the head of the queue.
  initial begin
    bit prev_busy;
    int t0, starts, occ, mn;
    exp_t h;
    logic [N-1:0] oh;
    prev_busy = 1'b0;
    t0 = 0;
    starts = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) prev_busy = 1'b0;
      else begin
        if (!busy) chk("idle_outputs", int'({grant, done, abort, eng_start, eng_stop, eng_len}), 0);
        else if (exp_q.size() == 0) chk("busy_without_transfer", int'(busy), 0);
        else begin
          h = exp_q[0];
          oh = N'(1) << h.idx;
          if (!prev_busy) begin
            t0 = cyc;
            starts = 0;
          end
          chk("grant", int'(grant), int'(oh));
          chk("eng_len", int'(eng_len), h.len);
          starts += int'(eng_start);
          if (done != '0 || abort != '0) begin
            chk("done", int'(done), h.ab ? 0 : int'(oh));
            chk("abort", int'(abort), h.ab ? int'(oh) : 0);
            chk("eng_stop", int'(eng_stop), int'(h.len != 0 || h.ab));
            chk("eng_start_count", starts, int'(h.len != 0));
            occ = cyc - t0 + 1;
            mn = h.len == 0 ? 1 : h.len + 3;
            if (exact_occ || h.len == 0) chk("occupancy", occ, mn);
            else chk("occupancy_min", int'(occ >= mn), 1);
            if (exp_ev_cyc >= 0) begin
              chk("event_cycle", cyc, exp_ev_cyc);
              exp_ev_cyc = -1;
            end
            void'(exp_q.pop_front());
            done_cnt++;
          end
        end
        prev_busy = busy;
      end
    end
  end

  // Engine strobe generator: 0 off, 1 every cycle, 2 every 2nd cycle, 3 random (gap<=3), 4 manual.
  initial begin
    int gap;
    gap = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 0) eng_byte = 1'b0;
      else if (mode == 1) eng_byte = 1'b1;
      else if (mode == 2) eng_byte = ~eng_byte;
      else if (mode == 3) begin
        if (gap >= 3 || $urandom_range(0, 1) == 1) begin
          eng_byte = 1'b1;
          gap = 0;
        end else begin
          eng_byte = 1'b0;
          gap++;
        end
      end
    end
  end

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && done_cnt < target; i++) begin
      @(negedge clk);
      #1;
    end
    chk("completions", done_cnt, target);
  endtask

  task automatic wait_start();
    for (int i = 0; i < 100 && !eng_start; i++) begin
      @(negedge clk);
      #1;
    end
    chk("eng_start_seen", int'(eng_start), 1);
  endtask

  task automatic run(input logic [N-1:0] mask, input int l0, input int l1, input int k, input int md, input bit drop);
    int lens[N];
    int w, target;
    lens[0] = l0;
    lens[1] = l1;
    req_len = {8'(l1), 8'(l0)};
    mode = md;
    exact_occ = md == 1;
    for (int j = 0; j < k; j++) begin
      w = rr_next(m_last, mask);
      exp_q.push_back('{idx: w, len: lens[w], ab: 1'b0});
      m_last = w;
    end
    target = done_cnt + k;
    req = mask;
    if (drop) begin
      for (int i = 0; i < 100 && !busy; i++) begin
        @(negedge clk);
        #1;
      end
      req = '0;
    end
    wait_done(target);
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({grant, done, abort, eng_start, eng_stop, eng_len, busy}), 0);
    reset_n = 1'b1;
    run(2'b11, 2, 2, 4, 3, 1'b0);
    run(2'b01, 3, 0, 1, 2, 1'b0);
    run(2'b10, 0, 0, 1, 3, 1'b0);
    mode = 1;
    repeat (6) @(negedge clk);
    run(2'b01, 5, 0, 1, 1, 1'b1);
`ifdef XFER_SCHED_TIMEOUT_EN
    begin
      int s, target;
      mode = 4;
      eng_byte = 1'b0;
      exact_occ = 1'b0;
      req_len = {8'd0, 8'd4};
      m_last = rr_next(m_last, 2'b01);
      exp_q.push_back('{idx: 0, len: 4, ab: 1'b1});
      target = done_cnt + 1;
      req = 2'b01;
      wait_start();
      @(posedge clk);
      #1;
      eng_byte = 1'b1;
      @(posedge clk);
      #1;
      s = cyc;
      exp_ev_cyc = s + TO + 1;
      @(posedge clk);
      #1;
      eng_byte = 1'b0;
      req = '0;
      wait_done(target);
      repeat (3) @(negedge clk);
    end
`endif
    req_len = {8'd20, 8'd20};
    mode = 3;
    exact_occ = 1'b0;
    exp_q.push_back('{idx: rr_next(m_last, 2'b10), len: 20, ab: 1'b0});
    req = 2'b10;
    wait_start();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    req = '0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("reset_mid_run", int'({grant, done, abort, eng_start, eng_stop, eng_len, busy}), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_last = N - 1;
    run(2'b11, 1, 1, 2, 1, 1'b0);
    for (int t = 0; t < 30; t++) begin
      logic [N-1:0] m;
      int l0, l1;
      m = N'($urandom_range(1, (1 << N) - 1));
      l0 = $urandom_range(0, 4) == 0 ? 0 : int'($urandom_range(1, 12));
      l1 = $urandom_range(0, 4) == 0 ? 0 : int'($urandom_range(1, 12));
      run(m, l0, l1, int'($urandom_range(1, 4)), $urandom_range(0, 2) == 0 ? 1 : 3, 1'b0);
    end
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
